// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : shares one memory port between instruction fetch and data access.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ready,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_f,
  output logic                    stall_m
);

  localparam int c_BE_W  = DATA_WIDTH / 8;
  localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_BUSY_I = 3'd1;
  localparam logic [2:0] c_BUSY_D = 3'd2;
  localparam logic [2:0] c_RESP_I = 3'd3;
  localparam logic [2:0] c_RESP_D = 3'd4;

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_starveCnt;
  logic               w_grantD;
  logic               w_grantI;

  // D wins ties until I has been passed over STARVE_LIMIT times in a row
  always_comb begin
    w_grantD = d_req & (~i_req | (r_starveCnt != c_STARVE_MAX));
    w_grantI = i_req & ~w_grantD;
  end

  assign i_ready = (r_state == c_RESP_I);
  assign d_ready = (r_state == c_RESP_D);
  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_starveCnt <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grantD) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_we ? d_be : {c_BE_W{1'b1}};
            r_state   <= c_BUSY_D;
            if (!i_req) begin
              r_starveCnt <= '0;
            end else if (r_starveCnt != c_STARVE_MAX) begin
              r_starveCnt <= r_starveCnt + 1'b1;
            end
          end else if (w_grantI) begin
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= i_addr;
            mem_wdata   <= '0;
            mem_be      <= {c_BE_W{1'b1}};
            r_state     <= c_BUSY_I;
            r_starveCnt <= '0;
          end
        end
        c_BUSY_I: begin
          if (mem_ack) begin
            i_rdata <= mem_rdata;
            mem_req <= 1'b0;
            r_state <= c_RESP_I;
          end
        end
        c_BUSY_D: begin
          if (mem_ack) begin
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            r_state <= c_RESP_D;
          end
        end
        c_RESP_I, c_RESP_D: r_state <= c_IDLE;
        default:            r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
